// File: rtl/checkbits_mon_pkg.sv
// Shared types and helpers for the checkpoint-bus sequence monitor.
// Holds the FSM state encoding, fail codes and field-width helper.
package checkbits_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PASS  = 2'd2,
        FAIL  = 2'd3
    } mon_state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_TIMEOUT = 2'd1;
    localparam logic [1:0] FC_ORDER   = 2'd2;
    localparam logic [1:0] FC_ILLEGAL = 2'd3;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int fld_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/checkbits_mon_stable.sv
// Registers the checkpoint bus and emits one qualify pulse per stable run.
// A run must hold STABLE consecutive samples; clr forces re-qualification.
module checkbits_stable_filter #(
    parameter int W      = 16,
    parameter int STABLE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] q,
    output logic         qual
);

    localparam int RW = $clog2(STABLE + 1);
    localparam logic [RW-1:0] STB = RW'(STABLE);

    logic [RW-1:0] run;
    logic [RW-1:0] run_nxt;
    logic          qual_nxt;

    // Run length restarts on a new value and saturates once qualified.
    always_comb begin
        run_nxt = run;
        if (din != q) begin
            run_nxt = RW'(1);
        end else if (run != STB) begin
            run_nxt = run + 1'b1;
        end
        qual_nxt = (run_nxt == STB) && ((run_nxt != run) || (din != q));
    end

    // Sample register, run counter and registered qualify pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            run  <= '0;
            qual <= 1'b0;
        end else if (clr) begin
            q    <= din;
            run  <= '0;
            qual <= 1'b0;
        end else begin
            q    <= din;
            run  <= run_nxt;
            qual <= qual_nxt;
        end
    end

endmodule

// File: rtl/checkbits_seq_monitor.sv
// Checks that firmware walks a list of checkpoint codes on a status bus.
// Reports pass, out-of-order, illegal-code and timeout on-chip.
module checkbits_seq_monitor
    import checkbits_mon_pkg::*;
#(
    parameter int                 W            = 16,
    parameter int                 N_CHK        = 3,
    parameter logic [N_CHK*W-1:0] CHK_PATTERNS = {16'hAB51, 16'hAB41, 16'hAB40},
    parameter int                 STABLE       = 2,
    parameter logic [W-1:0]       PREFIX_MASK  = 16'hFF00,
    parameter logic [W-1:0]       PREFIX_VAL   = 16'hAB00,
    parameter bit                 ORDERED      = 1'b1,
    parameter int                 TIMEOUT_W    = 24
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [W-1:0]                 checkbits_i,
    input  logic [TIMEOUT_W-1:0]         timeout_i,
    output logic                         busy_o,
    output logic                         pass_o,
    output logic                         fail_o,
    output logic [1:0]                   fail_code_o,
    output logic [fld_w(N_CHK+1)-1:0]    progress_o,
    output logic [N_CHK-1:0]             hit_mask_o,
    output logic                         hit_strobe_o,
    output logic [fld_w(N_CHK)-1:0]      hit_index_o,
    output logic [TIMEOUT_W-1:0]         cycle_count_o
);

    localparam int PW = fld_w(N_CHK + 1);
    localparam int IW = fld_w(N_CHK);

    mon_state_t           state, state_nxt;
    logic [W-1:0]         cb_q;
    logic                 qual;
    logic                 arm;
    logic [N_CHK-1:0]     eq;
    logic                 is_pfx;
    logic                 prev_hit;
    logic                 hit;
    logic [IW-1:0]        hit_idx;
    logic [N_CHK-1:0]     hit_oh;
    logic                 order_err;
    logic                 illegal_err;
    logic                 done;
    logic                 tmo;
    logic [TIMEOUT_W-1:0] cnt_inc;
    logic [PW-1:0]        prog_nxt;
    logic [N_CHK-1:0]     mask_nxt;
    logic [TIMEOUT_W-1:0] cnt_nxt;
    logic [1:0]           fc_nxt;
    logic                 strobe_nxt;
    logic [IW-1:0]        idx_nxt;

    assign arm = start_i & ~abort_i;

    checkbits_stable_filter #(
        .W      (W),
        .STABLE (STABLE)
    ) u_filter (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .clr  (arm),
        .din  (checkbits_i),
        .q    (cb_q),
        .qual (qual)
    );

    // Classify the sampled code against the expected list.
    always_comb begin
        hit         = 1'b0;
        hit_idx     = '0;
        hit_oh      = '0;
        prev_hit    = 1'b0;
        order_err   = 1'b0;
        illegal_err = 1'b0;
        is_pfx      = (cb_q & PREFIX_MASK) == PREFIX_VAL;
        for (int i = 0; i < N_CHK; i++) begin
            eq[i] = cb_q == CHK_PATTERNS[i*W +: W];
        end
        if (ORDERED) begin
            for (int i = 0; i < N_CHK; i++) begin
                if (eq[i] && progress_o == PW'(i)) begin
                    hit     = 1'b1;
                    hit_idx = IW'(i);
                    hit_oh  = N_CHK'(1) << i;
                end
                if (eq[i] && progress_o == PW'(i + 1)) begin
                    prev_hit = 1'b1;
                end
            end
            if (!hit && !prev_hit) begin
                order_err   = |eq;
                illegal_err = !(|eq) && is_pfx;
            end
        end else begin
            for (int i = N_CHK - 1; i >= 0; i--) begin
                if (eq[i] && !hit_mask_o[i]) begin
                    hit     = 1'b1;
                    hit_idx = IW'(i);
                    hit_oh  = N_CHK'(1) << i;
                end
            end
            illegal_err = !(|eq) && is_pfx;
        end
    end

    // Next state, progress, counter and fail code with fixed priority.
    always_comb begin
        state_nxt  = state;
        prog_nxt   = progress_o;
        mask_nxt   = hit_mask_o;
        cnt_nxt    = cycle_count_o;
        fc_nxt     = fail_code_o;
        strobe_nxt = 1'b0;
        idx_nxt    = hit_index_o;
        cnt_inc    = (&cycle_count_o) ? cycle_count_o : cycle_count_o + 1'b1;
        done       = qual && hit && (progress_o == PW'(N_CHK - 1));
        tmo        = (timeout_i != '0) && (cnt_inc == timeout_i);
        if (abort_i) begin
            state_nxt = IDLE;
            fc_nxt    = FC_NONE;
        end else if (start_i) begin
            state_nxt = ARMED;
            prog_nxt  = '0;
            mask_nxt  = '0;
            cnt_nxt   = '0;
            fc_nxt    = FC_NONE;
        end else if (state == ARMED) begin
            cnt_nxt = cnt_inc;
            if (qual && hit && (done || !tmo)) begin
                mask_nxt   = hit_mask_o | hit_oh;
                prog_nxt   = progress_o + 1'b1;
                strobe_nxt = 1'b1;
                idx_nxt    = hit_idx;
                if (done) begin
                    state_nxt = PASS;
                end
            end else if (tmo) begin
                state_nxt = FAIL;
                fc_nxt    = FC_TIMEOUT;
            end else if (qual && order_err) begin
                state_nxt = FAIL;
                fc_nxt    = FC_ORDER;
            end else if (qual && illegal_err) begin
                state_nxt = FAIL;
                fc_nxt    = FC_ILLEGAL;
            end
        end
    end

    // State and result registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            progress_o    <= '0;
            hit_mask_o    <= '0;
            cycle_count_o <= '0;
            fail_code_o   <= FC_NONE;
            hit_strobe_o  <= 1'b0;
            hit_index_o   <= '0;
        end else begin
            state         <= state_nxt;
            progress_o    <= prog_nxt;
            hit_mask_o    <= mask_nxt;
            cycle_count_o <= cnt_nxt;
            fail_code_o   <= fc_nxt;
            hit_strobe_o  <= strobe_nxt;
            hit_index_o   <= idx_nxt;
        end
    end

    assign busy_o = state == ARMED;
    assign pass_o = state == PASS;
    assign fail_o = state == FAIL;

endmodule
